// File: rtl/cdc_src_arbiter.sv
// Source-side front end of a two-phase toggle req/ack CDC channel, round-robin shared by N_REQ requesters.
// Optional ack watchdog with sticky timeout_o is built when CDC_ARB_TIMEOUT_EN is defined.
module cdc_src_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DW             = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic                async_req_o,
  output logic [DW-1:0]       async_data_o,
  output logic [IW-1:0]       async_src_o,
  input  logic                async_ack_i,
  output logic                busy_o
`ifdef CDC_ARB_TIMEOUT_EN
  ,
  output logic                timeout_o
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]             state;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          win;
  logic [IW-1:0]          ptr_next;
  logic                   any_vld;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_edge;
  logic                   ack_evt;
  logic [DW-1:0]          data_arr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = req_data_i[k*DW +: DW];
  end

  // Ack synchronizer followed by an edge-detect flop; each toggle yields one ack_evt pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_sync <= '0;
      ack_edge <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], async_ack_i};
      ack_edge <= ack_sync[SYNC_STAGES-1];
    end
  end

  assign ack_evt = ack_sync[SYNC_STAGES-1] != ack_edge;

  // Round-robin scan starting at ptr; the first valid requester found wins.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!any_vld && req_valid_i[IW'(idx)]) begin
        any_vld = 1'b1;
        win     = IW'(idx);
      end
    end
  end

  assign ptr_next = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);

  always_comb begin
    req_ready_o = '0;
    if (state == ST_IDLE && any_vld) req_ready_o[win] = 1'b1;
  end

  assign busy_o = (state == ST_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      async_req_o  <= 1'b0;
      async_data_o <= '0;
      async_src_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_vld) begin
            async_data_o <= data_arr[win];
            async_src_o  <= win;
            async_req_o  <= ~async_req_o;
            ptr          <= ptr_next;
            state        <= ST_WAIT;
          end
        end
        default: begin
          if (ack_evt) state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;

  // Counter is held at zero in IDLE, so it starts from zero on every WAIT entry and saturates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
      if (ack_evt) timeout_o <= 1'b1;
    end else begin
      if (tmo_cnt != CW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + CW'(1);
      if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// Bench for cdc_src_arbiter: directed and randomized transfers against a round-robin reference model.
module tb_cdc_src_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int SS  = 2;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            async_req_o;
  logic [DW-1:0]   async_data_o;
  logic [IW-1:0]   async_src_o;
  logic            async_ack_i = 1'b0;
  logic            busy_o;
`ifdef CDC_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  cdc_src_arbiter #(
    .N_REQ(N), .DW(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .async_req_o(async_req_o),
    .async_data_o(async_data_o),
    .async_src_o(async_src_o),
    .async_ack_i(async_ack_i),
    .busy_o(busy_o)
`ifdef CDC_ARB_TIMEOUT_EN
    ,
    .timeout_o(timeout_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int   n_pass   = 0;
  int   n_total  = 0;
  int   last_srv = N - 1;
  logic exp_tog  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Next requester to serve: the first valid one strictly after the last served, wrapping.
  function automatic int pick(input logic [N-1:0] v);
    for (int s = 1; s <= N; s++) begin
      int k;
      k = (last_srv + s) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic xfer(input logic [N-1:0] vld, input int hold, input bit vary,
                      input logic [N*DW-1:0] d);
    int            w;
    int            n;
    logic [DW-1:0] exp_d;
    logic [N-1:0]  exp_rdy;
    req_valid_i = vld;
    req_data_i  = d;
    #1;
    w       = pick(vld);
    exp_rdy = '0;
    exp_rdy[w] = 1'b1;
    chk("ready_grant", req_ready_o, exp_rdy);
    tick();
    exp_tog  = ~exp_tog;
    last_srv = w;
    exp_d    = d[w*DW +: DW];
    chk("req_toggle", async_req_o, exp_tog);
    chk("src_grant", async_src_o, w);
    chk("data_grant", async_data_o, exp_d);
    chk("busy_wait", busy_o, 1);
    for (int c = 0; c < hold; c++) begin
      req_data_i = rnd_data();
      if (vary) req_valid_i = N'($urandom);
      #1;
      chk("ready_wait", req_ready_o, 0);
      tick();
      chk("data_hold", async_data_o, exp_d);
      chk("src_hold", async_src_o, w);
    end
    async_ack_i = ~async_ack_i;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_o && n < 12);
    chk("ack_latency", n, SS + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    v;

    // Asynchronous reset before any clock edge
    #1 rst_i = 1'b1;
    #2;
    chk("rst_req", async_req_o, 0);
    chk("rst_data", async_data_o, 0);
    chk("rst_src", async_src_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
`ifdef CDC_ARB_TIMEOUT_EN
    chk("rst_timeout", timeout_o, 0);
`endif
    #20 rst_i = 1'b0;
    tick();

    // Round-robin with all four held valid
    for (int i = 0; i < 8; i++) begin
      xfer(4'hF, 1, 1'b0, rnd_data());
      chk("rr_sequence", async_src_o, i % 4);
    end

    // Single requester with a fixed word
    d = rnd_data();
    d[2*DW +: DW] = 32'hA5A5_0002;
    xfer(4'b0100, 3, 1'b0, d);
    chk("single_data", async_data_o, 32'hA5A5_0002);
    chk("single_src", async_src_o, 2);

`ifdef CDC_ARB_TIMEOUT_EN
    // Watchdog: never ack, then late ack
    chk("tmo_clear", timeout_o, 0);
    req_valid_i = 4'b0010;
    req_data_i  = rnd_data();
    #1;
    last_srv = pick(4'b0010);
    tick();
    exp_tog = ~exp_tog;
    chk("tmo_busy", busy_o, 1);
    for (int k = 1; k <= TMO + 3; k++) begin
      tick();
      chk("tmo_rise", timeout_o, (k >= TMO) ? 1 : 0);
    end
    chk("tmo_still_wait", busy_o, 1);
    async_ack_i = ~async_ack_i;
    repeat (SS + 1) tick();
    chk("tmo_idle", busy_o, 0);
    chk("tmo_sticky", timeout_o, 1);
`endif

    // Randomized masks; valid may change or drop during WAIT
    for (int i = 0; i < 30; i++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      xfer(v, $urandom_range(0, 4), 1'b1, rnd_data());
    end

    // Spurious ack in IDLE
    req_valid_i = '0;
    #1;
    async_ack_i = ~async_ack_i;
    repeat (6) tick();
    chk("spur_busy", busy_o, 0);
    chk("spur_req", async_req_o, exp_tog);
    chk("spur_ready", req_ready_o, 0);
`ifdef CDC_ARB_TIMEOUT_EN
    chk("spur_timeout", timeout_o, 1);
`endif
    xfer(4'b1001, 2, 1'b0, rnd_data());

    // Reset mid-transfer, mid-cycle
    req_valid_i = 4'b0001;
    req_data_i  = rnd_data();
    tick();
    chk("mid_busy_pre", busy_o, 1);
    req_valid_i = '0;
    async_ack_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_req", async_req_o, 0);
    chk("mid_rst_data", async_data_o, 0);
    chk("mid_rst_src", async_src_o, 0);
    chk("mid_rst_busy", busy_o, 0);
`ifdef CDC_ARB_TIMEOUT_EN
    chk("mid_rst_timeout", timeout_o, 0);
`endif
    #3 rst_i = 1'b0;
    exp_tog  = 1'b0;
    last_srv = N - 1;
    tick();
    xfer(4'b1000, 1, 1'b0, rnd_data());
    chk("post_rst_src", async_src_o, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
